// File: rtl/stream_mux_rr.sv
// N_CH-to-1 packet-aware stream multiplexer with a round-robin grant held for a whole packet.
// Define STREAM_MUX_RR_FIXED_PRIO_EN to replace round-robin with lowest-index-first arbitration.
module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      in_valid,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH-1:0]      in_last,
    output logic [N_CH-1:0]      in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic                 out_last,
    output logic [SW-1:0]        out_sel,
    input  logic                 out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_g;
`ifndef STREAM_MUX_RR_FIXED_PRIO_EN
    logic [SW-1:0]   r_ptr;
`endif

    logic            w_any_valid;
    logic            w_out_free;
    logic            w_sel_valid;
    logic            w_sel_last;
    logic            w_accept;
    logic [DW-1:0]   w_sel_data;
    logic [SW-1:0]   w_winner;

`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
    function automatic logic [SW-1:0] fixed_pick(input logic [N_CH-1:0] v);
        logic [SW-1:0] res;
        res = {SW{1'b0}};
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (v[SW'(k)]) begin
                res = SW'(k);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction
`else
    // Search upward from the channel after the last packet owner, wrapping at N_CH.
    function automatic logic [SW-1:0] rr_pick(input logic [N_CH-1:0] v,
                                              input logic [SW-1:0]   p);
        logic [SW-1:0] res;
        logic [SW-1:0] idx;
        logic          found;
        res   = {SW{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = SW'((int'(p) + k) % N_CH);
            if (!found && v[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction
`endif

    // Arbitration winner and the view of the granted channel.
    always_comb begin
        w_any_valid = |in_valid;
`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
        w_winner    = fixed_pick(in_valid);
`else
        w_winner    = rr_pick(in_valid, r_ptr);
`endif
        w_sel_valid = in_valid[r_g];
        w_sel_last  = in_last[r_g];
        w_sel_data  = {DW{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (r_g == SW'(i)) begin
                w_sel_data = in_data[i*DW +: DW];
            end else begin
                w_sel_data = w_sel_data;
            end
        end
    end

    // Only the granted channel is ever offered ready, and only when the output slot can take a beat.
    always_comb begin
        w_out_free = !out_valid || out_ready;
        in_ready   = {N_CH{1'b0}};
        if (r_state == ST_LOCK) begin
            in_ready[r_g] = w_out_free;
        end else begin
            in_ready = {N_CH{1'b0}};
        end
        w_accept = (r_state == ST_LOCK) && w_sel_valid && w_out_free;
    end

    // Grant FSM and the registered output slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_g       <= {SW{1'b0}};
`ifndef STREAM_MUX_RR_FIXED_PRIO_EN
            r_ptr     <= SW'(N_CH - 1);
`endif
            out_valid <= 1'b0;
            out_data  <= {DW{1'b0}};
            out_last  <= 1'b0;
            out_sel   <= {SW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_g     <= w_winner;
                        r_state <= ST_LOCK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (w_accept && w_sel_last) begin
`ifndef STREAM_MUX_RR_FIXED_PRIO_EN
                        r_ptr   <= r_g;
`endif
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_LOCK;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A drained slot keeps its last payload; only valid drops.
            if (w_accept) begin
                out_valid <= 1'b1;
                out_data  <= w_sel_data;
                out_last  <= w_sel_last;
                out_sel   <= r_g;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

endmodule
